// File: rtl/router_input_buffer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : HeMPS_defaults (package)
// Description : Shared router widths, port indices and input-buffer FSM states.
// Revision    : 1.0 - initial release
// ============================================================================
package HeMPS_defaults;

    localparam int TAM_FLIT   = 16;
    localparam int TAM_BUFFER = 16;
    localparam int NPORT      = 5;

    typedef logic [TAM_FLIT-1:0]            regflit;
    typedef logic [NPORT-1:0]               regNport;
    typedef logic [NPORT-1:0][TAM_FLIT-1:0] arrayNport_regflit;

    localparam int EAST  = 0;
    localparam int WEST  = 1;
    localparam int NORTH = 2;
    localparam int SOUTH = 3;
    localparam int LOCAL = 4;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_REQ     = 3'd1,
        S_HDR     = 3'd2,
        S_SIZE    = 3'd3,
        S_PAYLOAD = 3'd4
    } ibuf_state_t;

    typedef logic [$clog2(TAM_BUFFER)-1:0] ptr_t;

endpackage
`default_nettype wire

// File: rtl/router_buffer_fifo.sv
`default_nettype none
// ============================================================================
// Module      : router_buffer_fifo
// Description : Circular flit store with occupancy count and full/empty flags.
// Revision    : 1.0 - initial release
// ============================================================================
module router_buffer_fifo #(
    parameter int TAM_FLIT   = 16,
    parameter int TAM_BUFFER = 16
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                wr_req,
    input  logic [TAM_FLIT-1:0] wr_data,
    input  logic                rd_en,
    output logic [TAM_FLIT-1:0] rd_data,
    output logic                full,
    output logic                empty
);

    localparam int                c_ptr_w = $clog2(TAM_BUFFER);
    localparam logic [c_ptr_w-1:0] c_ptr_one = 1;
    localparam logic [c_ptr_w:0]   c_cnt_one = 1;
    localparam logic [c_ptr_w:0]   c_depth   = TAM_BUFFER[c_ptr_w:0];

    logic [TAM_FLIT-1:0] r_mem [TAM_BUFFER];
    logic [c_ptr_w-1:0]  r_wr_ptr;
    logic [c_ptr_w-1:0]  r_rd_ptr;
    logic [c_ptr_w:0]    r_count;
    logic                w_wr_en;
    logic                w_rd_en;

    assign full    = (r_count == c_depth);
    assign empty   = (r_count == '0);
    assign rd_data = r_mem[r_rd_ptr];
    assign w_rd_en = rd_en && !empty;
    // A write into a full FIFO is accepted only when the head pops on the same edge.
    assign w_wr_en = wr_req && (!full || w_rd_en);

    always_ff @(posedge clock) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_one;
            end
            if (w_rd_en) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_one;
            end
            if (w_wr_en && !w_rd_en) begin
                r_count <= r_count + c_cnt_one;
            end else if (!w_wr_en && w_rd_en) begin
                r_count <= r_count - c_cnt_one;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/router_input_buffer.sv
`default_nettype none
// ============================================================================
// Module      : router_input_buffer
// Description : Router input port buffer; requests routing per packet and
//               streams header, size and payload flits to the crossbar.
// Revision    : 1.0 - initial release
// ============================================================================
module router_input_buffer #(
    parameter int TAM_FLIT   = 16,
    parameter int TAM_BUFFER = 16
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                rx,
    input  logic [TAM_FLIT-1:0] data_in,
    output logic                credit_o,
    output logic                h,
    input  logic                ack_h,
    output logic                data_av,
    output logic [TAM_FLIT-1:0] data,
    input  logic                data_ack,
    output logic                sender
);

    import HeMPS_defaults::*;

    localparam logic [TAM_FLIT-1:0] c_flit_one = 1;

    ibuf_state_t         r_state;
    ibuf_state_t         w_state_next;
    logic [TAM_FLIT-1:0] r_flit_cnt;
    logic [TAM_FLIT-1:0] w_flit_cnt_next;
    logic                w_pop;
    logic                w_full;
    logic                w_empty;

    router_buffer_fifo #(
        .TAM_FLIT   (TAM_FLIT),
        .TAM_BUFFER (TAM_BUFFER)
    ) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .wr_req  (rx),
        .wr_data (data_in),
        .rd_en   (w_pop),
        .rd_data (data),
        .full    (w_full),
        .empty   (w_empty)
    );

    assign credit_o = !w_full;
    // Connection ownership follows the state so that reset clears it asynchronously.
    assign sender   = (r_state == S_HDR) || (r_state == S_SIZE) || (r_state == S_PAYLOAD);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_flit_cnt <= '0;
        end else begin
            r_state    <= w_state_next;
            r_flit_cnt <= w_flit_cnt_next;
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_flit_cnt_next = r_flit_cnt;
        h               = 1'b0;
        data_av         = 1'b0;
        w_pop           = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    w_state_next = S_REQ;
                end
            end
            S_REQ: begin
                h = 1'b1;
                if (ack_h) begin
                    w_state_next = S_HDR;
                end
            end
            S_HDR: begin
                data_av = 1'b1;
                if (data_ack) begin
                    w_pop        = 1'b1;
                    w_state_next = S_SIZE;
                end
            end
            S_SIZE: begin
                data_av = !w_empty;
                if (data_av && data_ack) begin
                    w_pop           = 1'b1;
                    w_flit_cnt_next = data;
                    w_state_next    = (data == '0) ? S_IDLE : S_PAYLOAD;
                end
            end
            S_PAYLOAD: begin
                data_av = !w_empty;
                if (data_av && data_ack) begin
                    w_pop           = 1'b1;
                    w_flit_cnt_next = r_flit_cnt - c_flit_one;
                    if (r_flit_cnt == c_flit_one) begin
                        w_state_next = S_IDLE;
                    end
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_router_input_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_router_input_buffer
// Description : Directed self-checking bench for router_input_buffer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_router_input_buffer;

    logic        clock    = 1'b0;
    logic        reset    = 1'b1;
    logic        rx       = 1'b0;
    logic [15:0] data_in  = 16'h0000;
    logic        ack_h    = 1'b0;
    logic        data_ack = 1'b0;
    logic        credit_o;
    logic        h;
    logic        data_av;
    logic [15:0] data;
    logic        sender;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [15:0] f [20];

    router_input_buffer #(
        .TAM_FLIT   (16),
        .TAM_BUFFER (16)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .rx       (rx),
        .data_in  (data_in),
        .credit_o (credit_o),
        .h        (h),
        .ack_h    (ack_h),
        .data_av  (data_av),
        .data     (data),
        .data_ack (data_ack),
        .sender   (sender)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [15:0] v);
        rx      = 1'b1;
        data_in = v;
        tick();
        rx      = 1'b0;
    endtask

    initial begin
        // reset state
        #2;
        chk("rst_credit", {31'd0, credit_o}, 32'd1);
        chk("rst_h", {31'd0, h}, 32'd0);
        chk("rst_data_av", {31'd0, data_av}, 32'd0);
        chk("rst_sender", {31'd0, sender}, 32'd0);
        tick();
        reset = 1'b0;
        tick();

        // single packet
        push(16'h0011);
        chk("t1_h_early", {31'd0, h}, 32'd0);
        chk("t1_data_hdr_early", {16'd0, data}, 32'h0011);
        chk("t1_av_early", {31'd0, data_av}, 32'd0);
        push(16'h0002);
        chk("t1_h", {31'd0, h}, 32'd1);
        push(16'hAAAA);
        push(16'hBBBB);
        chk("t1_h_hold", {31'd0, h}, 32'd1);
        chk("t1_sender_pre", {31'd0, sender}, 32'd0);
        ack_h = 1'b1;
        tick();
        ack_h = 1'b0;
        chk("t1_h_drop", {31'd0, h}, 32'd0);
        chk("t1_av", {31'd0, data_av}, 32'd1);
        chk("t1_sender", {31'd0, sender}, 32'd1);
        chk("t1_d0", {16'd0, data}, 32'h0011);
        data_ack = 1'b1;
        tick();
        chk("t1_d1", {16'd0, data}, 32'h0002);
        tick();
        chk("t1_d2", {16'd0, data}, 32'hAAAA);
        tick();
        chk("t1_d3", {16'd0, data}, 32'hBBBB);
        chk("t1_sender_mid", {31'd0, sender}, 32'd1);
        tick();
        data_ack = 1'b0;
        chk("t1_sender_end", {31'd0, sender}, 32'd0);
        chk("t1_av_end", {31'd0, data_av}, 32'd0);

        // ack_h outside S_REQ
        ack_h = 1'b1;
        tick();
        ack_h = 1'b0;
        chk("ign_ack_h", {31'd0, h}, 32'd0);
        chk("ign_ack_sender", {31'd0, sender}, 32'd0);

        // fill to 16 of a 20-flit packet, then wrap and drain
        f[0] = 16'h0022;
        f[1] = 16'h0012;
        for (int i = 2; i < 20; i++) f[i] = 16'hC000 + 16'(i);
        for (int i = 0; i < 16; i++) begin
            chk("t2_credit_fill", {31'd0, credit_o}, 32'd1);
            push(f[i]);
        end
        chk("t2_credit_full", {31'd0, credit_o}, 32'd0);
        chk("t2_h", {31'd0, h}, 32'd1);
        push(16'hDEAD);
        chk("t2_credit_discard", {31'd0, credit_o}, 32'd0);
        ack_h = 1'b1;
        tick();
        ack_h = 1'b0;
        chk("t2_d0", {16'd0, data}, 32'h0022);
        data_ack = 1'b1;
        tick();
        data_ack = 1'b0;
        chk("t2_credit_after_pop", {31'd0, credit_o}, 32'd1);
        chk("t2_d1", {16'd0, data}, 32'h0012);
        push(f[16]);
        chk("t2_credit_refull", {31'd0, credit_o}, 32'd0);

        // simultaneous push and pop while full
        data_ack = 1'b1;
        push(f[17]);
        chk("t4_credit_a", {31'd0, credit_o}, 32'd0);
        chk("t4_da", {16'd0, data}, {16'd0, f[2]});
        push(f[18]);
        chk("t4_credit_b", {31'd0, credit_o}, 32'd0);
        chk("t4_db", {16'd0, data}, {16'd0, f[3]});
        push(f[19]);
        chk("t4_credit_c", {31'd0, credit_o}, 32'd0);
        for (int k = 4; k < 20; k++) begin
            chk("t2_drain_data", {16'd0, data}, {16'd0, f[k]});
            chk("t2_drain_sender", {31'd0, sender}, 32'd1);
            tick();
        end
        data_ack = 1'b0;
        chk("t2_sender_end", {31'd0, sender}, 32'd0);
        chk("t2_av_end", {31'd0, data_av}, 32'd0);
        chk("t2_credit_end", {31'd0, credit_o}, 32'd1);

        // zero-size packet followed by another packet
        push(16'h0101);
        push(16'h0000);
        chk("t3_h", {31'd0, h}, 32'd1);
        ack_h = 1'b1;
        push(16'h0033);
        ack_h = 1'b0;
        chk("t3_av", {31'd0, data_av}, 32'd1);
        chk("t3_d0", {16'd0, data}, 32'h0101);
        data_ack = 1'b1;
        push(16'h0001);
        chk("t3_d1", {16'd0, data}, 32'h0000);
        push(16'h5555);
        chk("t3_sender_end", {31'd0, sender}, 32'd0);
        chk("t3_av_end", {31'd0, data_av}, 32'd0);
        chk("t3_h_idle", {31'd0, h}, 32'd0);
        data_ack = 1'b0;
        tick();
        chk("t3_h_next", {31'd0, h}, 32'd1);
        ack_h = 1'b1;
        tick();
        ack_h = 1'b0;
        data_ack = 1'b1;
        chk("t3_n0", {16'd0, data}, 32'h0033);
        tick();
        chk("t3_n1", {16'd0, data}, 32'h0001);
        tick();
        chk("t3_n2", {16'd0, data}, 32'h5555);
        chk("t3_n2_sender", {31'd0, sender}, 32'd1);
        tick();
        data_ack = 1'b0;
        chk("t3_n_sender_end", {31'd0, sender}, 32'd0);

        // stalled consumer during payload
        push(16'h0044);
        push(16'h0003);
        push(16'h1111);
        push(16'h2222);
        push(16'h3333);
        ack_h = 1'b1;
        tick();
        ack_h = 1'b0;
        data_ack = 1'b1;
        tick();
        tick();
        chk("t5_p0", {16'd0, data}, 32'h1111);
        tick();
        chk("t5_p1", {16'd0, data}, 32'h2222);
        chk("t5_sender_a", {31'd0, sender}, 32'd1);
        data_ack = 1'b0;
        tick();
        chk("t5_stall_a", {16'd0, data}, 32'h2222);
        chk("t5_stall_av", {31'd0, data_av}, 32'd1);
        tick();
        chk("t5_stall_b", {16'd0, data}, 32'h2222);
        data_ack = 1'b1;
        tick();
        chk("t5_p2", {16'd0, data}, 32'h3333);
        chk("t5_sender_b", {31'd0, sender}, 32'd1);
        tick();
        data_ack = 1'b0;
        chk("t5_sender_end", {31'd0, sender}, 32'd0);

        // reset mid-payload
        push(16'h0055);
        push(16'h0008);
        for (int i = 0; i < 8; i++) push(16'h6000 + 16'(i));
        ack_h = 1'b1;
        tick();
        ack_h = 1'b0;
        data_ack = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        chk("t6_d_before", {16'd0, data}, 32'h6003);
        chk("t6_sender_before", {31'd0, sender}, 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("t6_sender_rst", {31'd0, sender}, 32'd0);
        chk("t6_h_rst", {31'd0, h}, 32'd0);
        chk("t6_av_rst", {31'd0, data_av}, 32'd0);
        chk("t6_credit_rst", {31'd0, credit_o}, 32'd1);
        data_ack = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        chk("t6_h_post", {31'd0, h}, 32'd0);
        chk("t6_av_post", {31'd0, data_av}, 32'd0);
        push(16'h0066);
        chk("t6_new_head", {16'd0, data}, 32'h0066);
        push(16'h0001);
        chk("t6_new_h", {31'd0, h}, 32'd1);
        push(16'h7777);
        ack_h = 1'b1;
        tick();
        ack_h = 1'b0;
        data_ack = 1'b1;
        chk("t6_n0", {16'd0, data}, 32'h0066);
        tick();
        chk("t6_n1", {16'd0, data}, 32'h0001);
        tick();
        chk("t6_n2", {16'd0, data}, 32'h7777);
        tick();
        data_ack = 1'b0;
        chk("t6_sender_end", {31'd0, sender}, 32'd0);
        chk("t6_credit_end", {31'd0, credit_o}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
